// File: rtl/dmem_monitor_if.sv
// rtl/dmem_monitor_if.sv - CPU data-memory bus between the core and the monitor
interface dmem_monitor_if;
    logic [31:0] d_mem_addr;
    logic [31:0] d_mem_wdata;
    logic [3:0]  d_mem_wen;
    logic [31:0] d_mem_rdata;

    modport master (
        output d_mem_addr,
        output d_mem_wdata,
        output d_mem_wen,
        input  d_mem_rdata
    );

    modport slave (
        input  d_mem_addr,
        input  d_mem_wdata,
        input  d_mem_wen,
        output d_mem_rdata
    );
endinterface

// File: rtl/dmem_monitor.sv
// rtl/dmem_monitor.sv - data RAM with completion-flag watch, cycle budget and result sortedness scan
module dmem_monitor #(
    parameter int          MEM_SIZE_WORDS = 1024,
    parameter int          MAX_CYCLES     = 15000,
    parameter logic [31:0] FLAG_ADDR      = 32'h400,
    parameter logic [31:0] RESULT_ADDR    = 32'h300,
    parameter int          RESULT_LEN     = 10
) (
    input  logic         clk,
    input  logic         rst,
    dmem_monitor_if.slave bus,
    output logic         done,
    output logic         timeout,
    output logic         check_valid,
    output logic         sorted_ok,
    output logic [31:0]  cycle_count
);

    localparam int          IW        = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
    localparam int          SW        = (RESULT_LEN > 2) ? $clog2(RESULT_LEN - 1) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_SIZE_WORDS);
    localparam logic [IW-1:0] BASE    = IW'(RESULT_ADDR >> 2);
    localparam logic [SW-1:0] LAST    = SW'(RESULT_LEN - 2);
    localparam logic [31:0] MAX_C     = 32'(MAX_CYCLES);

    typedef enum logic [1:0] {RUN, CHECK, FIN, TOUT} state_t;

    state_t          state, state_next;
    logic [31:0]     count_next;
    logic [SW-1:0]   scan_idx, idx_next;
    logic            ok, ok_next;

    logic [31:0]     mem [MEM_SIZE_WORDS];

    logic            in_range;
    logic [IW-1:0]   word_idx;
    logic            flag_hit;
    logic [IW-1:0]   lo_idx, hi_idx;
    logic [31:0]     pair_lo, pair_hi;

    assign in_range = bus.d_mem_addr < MEM_BYTES;
    assign word_idx = bus.d_mem_addr[IW+1:2];
    assign flag_hit = (bus.d_mem_wen == 4'b1111) && (bus.d_mem_addr == FLAG_ADDR)
                   && (bus.d_mem_wdata == 32'd1);

    // Loads are combinational; anything outside the RAM reads as zero
    assign bus.d_mem_rdata = in_range ? mem[word_idx] : 32'h0;

    // The scan compares two adjacent result words per cycle
    assign lo_idx  = BASE + IW'(scan_idx);
    assign hi_idx  = lo_idx + IW'(1);
    assign pair_lo = mem[lo_idx];
    assign pair_hi = mem[hi_idx];

    // Byte-lane stores, accepted only while the program is still running
    always_ff @(posedge clk) begin
        if (!rst && state == RUN && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.d_mem_wen[k]) begin
                    mem[word_idx][8*k +: 8] <= bus.d_mem_wdata[8*k +: 8];
                end
            end
        end
    end

    // Next-state logic: completion beats timeout when both land on the same edge
    always_comb begin
        state_next = state;
        count_next = cycle_count;
        idx_next   = scan_idx;
        ok_next    = ok;
        case (state)
            RUN: begin
                count_next = cycle_count + 32'd1;
                if (flag_hit) begin
                    state_next = CHECK;
                    idx_next   = '0;
                    ok_next    = 1'b1;
                end else if (count_next == MAX_C) begin
                    state_next = TOUT;
                end
            end
            CHECK: begin
                if (pair_lo > pair_hi) begin
                    ok_next = 1'b0;
                end
                if (scan_idx == LAST) begin
                    state_next = FIN;
                end else begin
                    idx_next = scan_idx + SW'(1);
                end
            end
            FIN:     ;
            TOUT:    ;
            default: state_next = RUN;
        endcase
    end

    // State, counter and scan registers; reset aborts any count or scan in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            cycle_count <= 32'd0;
            scan_idx    <= '0;
            ok          <= 1'b0;
        end else begin
            state       <= state_next;
            cycle_count <= count_next;
            scan_idx    <= idx_next;
            ok          <= ok_next;
        end
    end

    assign done        = (state == CHECK) || (state == FIN);
    assign timeout     = (state == TOUT);
    assign check_valid = (state == FIN);
    assign sorted_ok   = check_valid && ok;

endmodule

// File: tb/tb_dmem_monitor.sv
// tb/tb_dmem_monitor.sv - self-checking bench for dmem_monitor
module tb_dmem_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done, timeout, check_valid, sorted_ok;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    dmem_monitor_if bus();

    dmem_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .done        (done),
        .timeout     (timeout),
        .check_valid (check_valid),
        .sorted_ok   (sorted_ok),
        .cycle_count (cycle_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
        logic [31:0] rd_addr;
        logic [31:0] exp_rd;
        logic        exp_done;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    sb_t         sb_q[$];
    vec_t        tbl [11];
    logic [31:0] arr [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        bus.d_mem_addr  = a;
        bus.d_mem_wdata = d;
        bus.d_mem_wen   = w;
        tick();
        bus.d_mem_wen   = 4'b0000;
    endtask

    task automatic read_expect(input logic [31:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        bus.d_mem_wen  = 4'b0000;
        bus.d_mem_addr = a;
        sb_q.push_back('{name, exp});
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check(e.name, bus.d_mem_rdata, e.exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"},  {31'd0, done},        32'd0);
        check({tag, "_tout"},  {31'd0, timeout},     32'd0);
        check({tag, "_cv"},    {31'd0, check_valid}, 32'd0);
        check({tag, "_sok"},   {31'd0, sorted_ok},   32'd0);
        check({tag, "_count"}, cycle_count,          32'd0);
    endtask

    task automatic reset_dut(input string tag);
        bus.d_mem_wen = 4'b0000;
        rst = 1'b1;
        #1;
        check_idle_outputs(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_sort(input logic [31:0] a [10], input logic exp_ok, input string name);
        reset_dut({name, "_rst"});
        for (int i = 0; i < 10; i++) write(32'h300 + 32'(4 * i), a[i], 4'b1111);
        write(32'h400, 32'd1, 4'b1111);
        repeat (8) tick();
        check({name, "_cv_early"}, {31'd0, check_valid}, 32'd0);
        check({name, "_sok_early"}, {31'd0, sorted_ok}, 32'd0);
        tick();
        check({name, "_cv"}, {31'd0, check_valid}, 32'd1);
        check({name, "_sok"}, {31'd0, sorted_ok}, {31'd0, exp_ok});
    endtask

    initial begin
        bus.d_mem_addr  = 32'h0;
        bus.d_mem_wdata = 32'h0;
        bus.d_mem_wen   = 4'b0000;

        tbl[0]  = '{32'h0000, 32'h12345678, 4'b1111, 32'h0000, 32'h12345678, 1'b0};
        tbl[1]  = '{32'h0010, 32'h11223344, 4'b1111, 32'h0010, 32'h11223344, 1'b0};
        tbl[2]  = '{32'h0010, 32'hAABBCCDD, 4'b0010, 32'h0010, 32'h1122CC44, 1'b0};
        tbl[3]  = '{32'h0010, 32'h55667788, 4'b1000, 32'h0010, 32'h5522CC44, 1'b0};
        tbl[4]  = '{32'h0010, 32'h00000099, 4'b0001, 32'h0010, 32'h5522CC99, 1'b0};
        tbl[5]  = '{32'h1000, 32'hDEADBEEF, 4'b1111, 32'h1000, 32'h00000000, 1'b0};
        tbl[6]  = '{32'h1000, 32'hDEADBEEF, 4'b1111, 32'h0000, 32'h12345678, 1'b0};
        tbl[7]  = '{32'h0FFC, 32'hCAFEF00D, 4'b1111, 32'h0FFC, 32'hCAFEF00D, 1'b0};
        tbl[8]  = '{32'h0400, 32'h00000002, 4'b1111, 32'h0400, 32'h00000002, 1'b0};
        tbl[9]  = '{32'h0400, 32'h00000001, 4'b0011, 32'h0400, 32'h00000001, 1'b0};
        tbl[10] = '{32'h0400, 32'h00000101, 4'b1111, 32'h0400, 32'h00000101, 1'b0};

        #2;
        reset_dut("rst0");

        for (int i = 0; i < 11; i++) begin
            write(tbl[i].addr, tbl[i].wdata, tbl[i].wen);
            read_expect(tbl[i].rd_addr, tbl[i].exp_rd, $sformatf("vec%0d_rd", i));
            check($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, tbl[i].exp_done});
        end
        check("vec_count", cycle_count, 32'd11);

        reset_dut("sorted_rst");
        for (int i = 0; i < 10; i++) write(32'h300 + 32'(4 * i), 32'(i + 1), 4'b1111);
        repeat (189) tick();
        check("pre_flag_count", cycle_count, 32'd199);
        check("pre_flag_done", {31'd0, done}, 32'd0);
        write(32'h400, 32'd1, 4'b1111);
        check("flag_done", {31'd0, done}, 32'd1);
        check("flag_count", cycle_count, 32'd200);
        check("flag_cv", {31'd0, check_valid}, 32'd0);
        repeat (8) tick();
        check("scan_cv_early", {31'd0, check_valid}, 32'd0);
        check("scan_sok_early", {31'd0, sorted_ok}, 32'd0);
        check("scan_count_hold", cycle_count, 32'd200);
        tick();
        check("scan_cv", {31'd0, check_valid}, 32'd1);
        check("scan_sok", {31'd0, sorted_ok}, 32'd1);
        check("scan_tout", {31'd0, timeout}, 32'd0);
        write(32'h300, 32'd99, 4'b1111);
        read_expect(32'h300, 32'd1, "fin_frozen");

        arr = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd4, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
        run_sort(arr, 1'b0, "mid_swap");
        arr = '{32'd2, 32'd1, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
        run_sort(arr, 1'b0, "first_swap");
        arr = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd10, 32'd9};
        run_sort(arr, 1'b0, "last_swap");
        arr = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5};
        run_sort(arr, 1'b1, "equal");
        arr = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'hFFFFFFFF};
        run_sort(arr, 1'b1, "unsigned_top");
        arr = '{32'd1, 32'hFFFFFFFF, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
        run_sort(arr, 1'b0, "unsigned_mid");

        arr = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
        run_sort(arr, 1'b1, "abort_setup");
        reset_dut("abort_rst");
        write(32'h400, 32'd1, 4'b1111);
        repeat (3) tick();
        check("abort_done_before", {31'd0, done}, 32'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("abort_count_restart", cycle_count, 32'd1);
        check("abort_done_after", {31'd0, done}, 32'd0);
        for (int i = 0; i < 10; i++)
            read_expect(32'h300 + 32'(4 * i), 32'(i + 1), $sformatf("abort_arr%0d", i));
        write(32'h20, 32'hA5A5A5A5, 4'b1111);
        read_expect(32'h20, 32'hA5A5A5A5, "abort_run_write");

        reset_dut("race_rst");
        repeat (14999) tick();
        check("race_pre_count", cycle_count, 32'd14999);
        write(32'h400, 32'd1, 4'b1111);
        check("race_done", {31'd0, done}, 32'd1);
        check("race_tout", {31'd0, timeout}, 32'd0);
        check("race_count", cycle_count, 32'd15000);
        repeat (9) tick();
        check("race_cv", {31'd0, check_valid}, 32'd1);

        reset_dut("tout_rst");
        write(32'h20, 32'h5A5A5A5A, 4'b1111);
        repeat (14997) tick();
        check("tout_pre2_count", cycle_count, 32'd14998);
        tick();
        check("tout_pre1", {31'd0, timeout}, 32'd0);
        tick();
        check("tout_flag", {31'd0, timeout}, 32'd1);
        check("tout_count", cycle_count, 32'd15000);
        check("tout_done", {31'd0, done}, 32'd0);
        repeat (3) tick();
        check("tout_count_hold", cycle_count, 32'd15000);
        write(32'h20, 32'h0BADF00D, 4'b1111);
        read_expect(32'h20, 32'h5A5A5A5A, "tout_frozen");
        write(32'h400, 32'd1, 4'b1111);
        check("tout_flag_ignored", {31'd0, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
